tt_sweep_capture: RTL and testbench
===================================

# tt_sweep_capture

Sequential truth-table extractor for the 7-input majority-network classification datapath. Sits directly upstream of a combinational 7-input function block and also consumes its output. It drives all 128 input minterms into that block in order and assembles the single-bit responses into a 128-bit truth table. It presents the table with a ones-count over a valid/ready handshake to the downstream classifier.

## Interface
- `LAT`, default 0: register stages between `x` and `f_in` in the function block; legal range 0..3.
- `clk`  in  1  system clock, all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request a sweep; honoured only in IDLE.
- `busy`  out  1  high whenever state is not IDLE.
- `x`  out  7  minterm driven to the function block; `x[i]` = input `xi`.
- `f_in`  in  1  function output, valid `LAT` cycles after the matching `x`.
- `tt`  out  128  captured truth table; bit m = f(minterm m).
- `ones`  out  8  population count of `tt`, range 0..128.
- `tt_valid`  out  1  `tt` and `ones` are complete and stable.
- `tt_ready`  in  1  downstream accepts the table.

## Operation
- FSM states:
  - IDLE → SWEEP on `start`.
  - SWEEP → DRAIN after `x`=127 is issued.
  - DRAIN → HOLD after the last capture.
  - HOLD → IDLE on `tt_valid && tt_ready`.
- DRAIN lasts exactly `LAT` cycles. With `LAT`=0, SWEEP goes to HOLD directly.
- SWEEP:
  - The 7-bit issue counter drives `x` and increments by 1 each cycle, from 0 to 127 with no gaps.
  - The counter does not wrap. Its 127→0 step coincides with leaving SWEEP.
- Capture:
  - A `LAT`-deep delay line carries the issued index and an issue-valid flag.
  - When the delayed flag is high, `tt[idx]` ← `f_in`, and `ones` increments by `f_in`.
  - `ones` is 8 bits wide so it holds 128 without overflow.
- Start of sweep: entering SWEEP clears `tt` and `ones` in the same edge.
- HOLD: `tt` and `ones` are frozen and `tt_valid`=1.
- `x` is 0 in every state except SWEEP.
- `start` outside IDLE is ignored, and is not queued.
- `start` and `tt_ready` high together in HOLD: the handshake completes and the FSM returns to IDLE. `start` is not honoured until the next cycle.
- Reset outputs:
  - `busy`=0, `x`=0, `tt`=0, `ones`=0, `tt_valid`=0.
  - The FSM goes to IDLE and the delay line is flushed.
- Reset mid-sweep or in HOLD: the partial or complete table is discarded, and all outputs return to their reset values on the next edge.
- Results persist after the handshake: `tt` and `ones` keep their values in IDLE until the next `start`.

## Timing
- `start` is sampled high in IDLE at edge E. From E: `busy`=1, `x`=0. Call the cycle after E cycle C0.
- Issue: `x`=m during cycle C0+m, for m = 0..127.
- Capture: bit m is captured at the end of cycle C0+m+`LAT`.
- `tt_valid` rises in cycle C0+128+`LAT` and stays high until the handshake edge.
- Sweep-to-valid latency is 129+`LAT` cycles from the `start` edge.
- `busy` falls on the edge that completes the handshake.
- Throughput is one table per 130+`LAT` cycles when `tt_ready` is tied high and `start` is asserted in IDLE immediately.
- All outputs are registered, with no combinational input-to-output paths.

## Structure
- Package `tt_sweep_pkg`:
  - `N_IN`=7 and `TT_W`=2**`N_IN`.
  - Enum `sweep_state_e` {IDLE, SWEEP, DRAIN, HOLD}.
  - Width of `ones`, defined as `$clog2(TT_W+1)`.
- One sub-module, `tt_delay_line`. It is a parameterised `LAT`-deep register pipe for {valid, 7-bit index}. `LAT`=0 gives a pass-through.
- The FSM, counter, table register and popcount accumulator live in the top.

## Test plan
- `LAT`=0, `f_in`=0, `tt_ready`=1 → `tt`=0 and `ones`=0. `tt_valid` rises exactly 129 cycles after the `start` edge.
- `LAT`=0, `f_in`=`x[0]` → `tt`=0xAAAA…AAAA (32 hex digits) and `ones`=64.
- `LAT`=2, bench models a 2-cycle-delayed AND of all inputs → `tt`=1<<127 and `ones`=1. `tt_valid` rises at cycle 131.
- `LAT`=1, bench models the 7-input majority-network function under classification → `tt`=0xfeeaeaeafee8e880fee8e880a8a8a880 and `ones`=64.
- `tt_ready` held low for 20 cycles, with `start` pulsed during HOLD:
  - `tt` is stable and `tt_valid`=1 throughout.
  - The `start` pulse is ignored.
  - One handshake is followed by IDLE and `busy`=0.
- `rst` asserted at cycle C0+60:
  - Next cycle: all outputs are 0 and the state is IDLE.
  - A new `start` then yields a full, correct table.

Source files
------------

// File: rtl/tt_sweep_capture_pkg.sv
// Shared types and sizes for the 7-input truth-table sweep/capture block.
// The popcount width is sized so a table of all ones (128) still fits.
package tt_sweep_pkg;
    localparam int N_IN   = 7;
    localparam int TT_W   = 2 ** N_IN;
    localparam int ONES_W = $clog2(TT_W + 1);

    localparam logic [N_IN-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        HOLD
    } sweep_state_e;

    typedef struct packed {
        logic            valid;
        logic [N_IN-1:0] idx;
    } issue_t;
endpackage

// File: rtl/tt_sweep_capture_if.sv
// Handshake and function-block bus of the sweep/capture block.
// The master side is the capture block; the slave side is the function block plus the classifier.
interface tt_sweep_capture_if;
    import tt_sweep_pkg::*;

    logic              start;
    logic              busy;
    logic [N_IN-1:0]   x;
    logic              f_in;
    logic [TT_W-1:0]   tt;
    logic [ONES_W-1:0] ones;
    logic              tt_valid;
    logic              tt_ready;

    modport master (
        input  start, f_in, tt_ready,
        output busy, x, tt, ones, tt_valid
    );

    modport slave (
        output start, f_in, tt_ready,
        input  busy, x, tt, ones, tt_valid
    );
endinterface

// File: rtl/tt_sweep_capture_delay_line.sv
// LAT-deep register pipe that carries {valid, index}, so each capture lines up with its f_in.
// With LAT=0 the pipe is a plain wire.
module tt_delay_line
    import tt_sweep_pkg::*;
#(
    parameter int LAT = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  issue_t in_i,
    output issue_t out_o
);
    if (LAT == 0) begin : g_bypass
        logic unused_lat0;
        assign unused_lat0 = clk ^ rst;
        assign out_o       = in_i;
    end else begin : g_pipe
        issue_t stage_q [LAT];
        issue_t stage_d [LAT];

        always_comb begin
            stage_d[0] = in_i;
            for (int i = 1; i < LAT; i++) stage_d[i] = stage_q[i-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
            end else begin
                for (int i = 0; i < LAT; i++) stage_q[i] <= stage_d[i];
            end
        end

        assign out_o = stage_q[LAT-1];
    end
endmodule

// File: rtl/tt_sweep_capture.sv
// Drives all 128 minterms into a function block and assembles its responses into a truth table.
// The finished table and its ones-count are offered downstream over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; the last table and its count are still presented
// SWEEP | issuing x = 0..127, one per cycle
// DRAIN | waiting LAT cycles for the last responses to arrive
// HOLD  | table complete, tt_valid high until tt_ready
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int LAT = 0
) (
    input logic               clk,
    input logic               rst,
    tt_sweep_capture_if.master bus
);
    sweep_state_e      state_q, state_d;
    logic [N_IN-1:0]   cnt_q, cnt_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    issue_t            issue, capture;
    logic              last_capture;

    assign issue        = {state_q == SWEEP, cnt_q};
    assign last_capture = capture.valid && (capture.idx == IDX_LAST);

    tt_delay_line #(.LAT(LAT)) u_delay (
        .clk   (clk),
        .rst   (rst),
        .in_i  (issue),
        .out_o (capture)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SWEEP;
            SWEEP:   if (cnt_q == IDX_LAST) state_d = (LAT == 0) ? HOLD : DRAIN;
            DRAIN:   if (last_capture) state_d = HOLD;
            HOLD:    if (bus.tt_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state_q != IDLE);
        bus.tt_valid = (state_q == HOLD);
        bus.x        = cnt_q;
        bus.tt       = tt_q;
        bus.ones     = ones_q;
    end

    // The counter's natural 127->0 wrap coincides with leaving SWEEP, so x is 0 everywhere else.
    always_comb begin
        cnt_d  = (state_q == SWEEP) ? cnt_q + 1'b1 : '0;
        tt_d   = tt_q;
        ones_d = ones_q;
        if (state_q == IDLE && bus.start) begin
            tt_d   = '0;
            ones_d = '0;
        end else if (capture.valid) begin
            tt_d[capture.idx] = bus.f_in;
            ones_d            = ones_q + ONES_W'(bus.f_in);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tt_q   <= '0;
            ones_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tt_q   <= tt_d;
            ones_q <= ones_d;
        end
    end
endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture with LAT = 0, 1 and 2 instances side by side.
// Each instance has its own function-block model driving f_in.
module tb_tt_sweep_capture;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tt_sweep_capture_if bus0();
    tt_sweep_capture_if bus1();
    tt_sweep_capture_if bus2();

    tt_sweep_capture #(.LAT(0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    tt_sweep_capture #(.LAT(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    tt_sweep_capture #(.LAT(2)) u2 (.clk(clk), .rst(rst), .bus(bus2));

    logic start_r [3];
    logic ready_r [3];
    assign bus0.start = start_r[0];
    assign bus1.start = start_r[1];
    assign bus2.start = start_r[2];
    assign bus0.tt_ready = ready_r[0];
    assign bus1.tt_ready = ready_r[1];
    assign bus2.tt_ready = ready_r[2];

    // Function-block models: LAT0 is constant 0 or x[0], LAT1 is a lookup of the majority network, LAT2 is a delayed AND.
    logic         mode0;
    logic [127:0] maj_tt;
    logic         f1_q, f2a_q, f2b_q;
    assign bus0.f_in = mode0 ? bus0.x[0] : 1'b0;
    always @(posedge clk) f1_q <= maj_tt[bus1.x];
    always @(posedge clk) begin
        f2a_q <= &bus2.x;
        f2b_q <= f2a_q;
    end
    assign bus1.f_in = f1_q;
    assign bus2.f_in = f2b_q;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] g_tt(input int k);
        case (k)
            0:       return bus0.tt;
            1:       return bus1.tt;
            default: return bus2.tt;
        endcase
    endfunction
    function automatic logic [7:0] g_ones(input int k);
        case (k)
            0:       return bus0.ones;
            1:       return bus1.ones;
            default: return bus2.ones;
        endcase
    endfunction
    function automatic logic [6:0] g_x(input int k);
        case (k)
            0:       return bus0.x;
            1:       return bus1.x;
            default: return bus2.x;
        endcase
    endfunction
    function automatic logic g_busy(input int k);
        case (k)
            0:       return bus0.busy;
            1:       return bus1.busy;
            default: return bus2.busy;
        endcase
    endfunction
    function automatic logic g_valid(input int k);
        case (k)
            0:       return bus0.tt_valid;
            1:       return bus1.tt_valid;
            default: return bus2.tt_valid;
        endcase
    endfunction

    // Full sweep with tt_ready high; cycle 1 is C0, so tt_valid is expected in cycle 129+LAT.
    task automatic run_sweep(input int k, input logic [127:0] exp_tt, input int exp_ones,
                             input int exp_lat, input string tag);
        int cyc;
        int xbad;
        int ex;
        ready_r[k] = 1'b1;
        start_r[k] = 1'b1;
        @(negedge clk);
        start_r[k] = 1'b0;
        cyc  = 1;
        xbad = 0;
        chk({tag, "_busy_c0"}, 128'(g_busy(k)), 128'd1);
        while (!g_valid(k) && cyc < 400) begin
            ex = (cyc <= 128) ? cyc - 1 : 0;
            if (int'(g_x(k)) != ex) xbad++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_x_seq_errs"}, 128'(xbad), 128'd0);
        chk({tag, "_valid_cycle"}, 128'(cyc), 128'(exp_lat));
        chk({tag, "_tt"}, g_tt(k), exp_tt);
        chk({tag, "_ones"}, 128'(g_ones(k)), 128'(exp_ones));
        @(negedge clk);
        chk({tag, "_busy_after_hs"}, 128'(g_busy(k)), 128'd0);
        chk({tag, "_valid_after_hs"}, 128'(g_valid(k)), 128'd0);
        chk({tag, "_tt_persist"}, g_tt(k), exp_tt);
        chk({tag, "_x_idle"}, 128'(g_x(k)), 128'd0);
    endtask

    typedef struct {
        int           k;
        logic         mode;
        logic [127:0] exp_tt;
        int           exp_ones;
        int           exp_lat;
        string        tag;
    } vec_t;

    localparam logic [127:0] TT_ALT = 128'haaaa_aaaa_aaaa_aaaa_aaaa_aaaa_aaaa_aaaa;
    localparam logic [127:0] TT_MAJ = 128'hfeea_eaea_fee8_e880_fee8_e880_a8a8_a880;

    vec_t vecs [4];

    initial begin
        int cyc;
        maj_tt = TT_MAJ;
        vecs[0] = '{k: 0, mode: 1'b0, exp_tt: '0,                 exp_ones: 0,  exp_lat: 129, tag: "lat0_zero"};
        vecs[1] = '{k: 0, mode: 1'b1, exp_tt: TT_ALT,             exp_ones: 64, exp_lat: 129, tag: "lat0_x0"};
        vecs[2] = '{k: 2, mode: 1'b0, exp_tt: {1'b1, 127'b0},     exp_ones: 1,  exp_lat: 131, tag: "lat2_and"};
        vecs[3] = '{k: 1, mode: 1'b0, exp_tt: TT_MAJ,             exp_ones: 64, exp_lat: 130, tag: "lat1_maj"};

        rst   = 1'b1;
        mode0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_r[k] = 1'b0;
            ready_r[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_busy%0d", k), 128'(g_busy(k)), 128'd0);
            chk($sformatf("rst_valid%0d", k), 128'(g_valid(k)), 128'd0);
            chk($sformatf("rst_tt%0d", k), g_tt(k), 128'd0);
            chk($sformatf("rst_ones%0d", k), 128'(g_ones(k)), 128'd0);
            chk($sformatf("rst_x%0d", k), 128'(g_x(k)), 128'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            mode0 = vecs[v].mode;
            run_sweep(vecs[v].k, vecs[v].exp_tt, vecs[v].exp_ones, vecs[v].exp_lat, vecs[v].tag);
            @(negedge clk);
        end

        // tt_ready held low in HOLD for 20 cycles with a start pulse in the middle
        mode0      = 1'b1;
        ready_r[0] = 1'b0;
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        cyc = 1;
        while (!bus0.tt_valid && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("hold_valid_cycle", 128'(cyc), 128'd129);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("hold_tt_c%0d", i), bus0.tt, TT_ALT);
            chk($sformatf("hold_valid_c%0d", i), 128'(bus0.tt_valid), 128'd1);
            start_r[0] = (i == 5);
            @(negedge clk);
        end
        chk("hold_ones", 128'(bus0.ones), 128'd64);
        // start and tt_ready together: handshake completes, start is dropped
        start_r[0] = 1'b1;
        ready_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        chk("hs_busy", 128'(bus0.busy), 128'd0);
        chk("hs_valid", 128'(bus0.tt_valid), 128'd0);
        @(negedge clk);
        chk("hs_no_queue_busy", 128'(bus0.busy), 128'd0);
        chk("hs_no_queue_x", 128'(bus0.x), 128'd0);
        chk("hs_persist_tt", bus0.tt, TT_ALT);

        // reset asserted during cycle C0+60
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        cyc = 1;
        while (cyc < 61) begin
            @(negedge clk);
            cyc++;
        end
        chk("pre_rst_x", 128'(bus0.x), 128'd60);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 128'(bus0.busy), 128'd0);
        chk("mid_rst_x", 128'(bus0.x), 128'd0);
        chk("mid_rst_tt", bus0.tt, 128'd0);
        chk("mid_rst_ones", 128'(bus0.ones), 128'd0);
        chk("mid_rst_valid", 128'(bus0.tt_valid), 128'd0);
        @(negedge clk);
        chk("post_rst_idle", 128'(bus0.busy), 128'd0);
        run_sweep(0, TT_ALT, 64, 129, "after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
